// File: rtl/cpu_mul_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | cpu_mul_sequencer_pkg : mul-op encoding, FSM states and result helpers.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package cpu_mul_sequencer_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_FIXUP = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic logic [31:0] select_half(input mul_op_e op, input logic [63:0] prod);
        return (op == MUL_OP_MUL) ? prod[31:0] : prod[63:32];
    endfunction

    // Unsigned high half corrected into signed(op1) x unsigned(op2).
    function automatic logic [31:0] mulhsu_fixup(input logic [31:0] prod_hi,
                                                 input logic [31:0] op1,
                                                 input logic [31:0] op2);
        return prod_hi - (op1[31] ? op2 : 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/CPU_Multiply.sv
// +--------------------------------------------------------------------------+
// | CPU_Multiply : 32x32 multiplier, product ready four cycles after latch.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module CPU_Multiply (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_latch,
    input  logic        i_signed,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    output logic        o_ready,
    output logic [63:0] o_product
);

    localparam logic [1:0] LAST_CNT = 2'd3;

    logic        busy_q;
    logic        sgn_q;
    logic [1:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] w_a;
    logic [63:0] w_b;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_q <= 1'b0;
            sgn_q  <= 1'b0;
            cnt_q  <= 2'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
        end else if (!busy_q) begin
            if (i_latch) begin
                busy_q <= 1'b1;
                cnt_q  <= 2'd0;
                a_q    <= i_op1;
                b_q    <= i_op2;
                sgn_q  <= i_signed;
            end
        end else if (cnt_q == LAST_CNT) begin
            busy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 2'd1;
        end
    end

    // Sign-extend to 64 bits so the low 64 bits of the product are exact.
    assign w_a       = {{32{sgn_q & a_q[31]}}, a_q};
    assign w_b       = {{32{sgn_q & b_q[31]}}, b_q};
    assign o_product = w_a * w_b;
    assign o_ready   = busy_q && (cnt_q == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/cpu_mul_sequencer.sv
// +--------------------------------------------------------------------------+
// | cpu_mul_sequencer : two-port arbiter/sequencer around CPU_Multiply.      |
// | Optional result cache: define CPU_MUL_RESULT_CACHE_EN.   Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module cpu_mul_sequencer #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_p0_request,
    input  logic [1:0]  i_p0_op,
    input  logic [31:0] i_p0_op1,
    input  logic [31:0] i_p0_op2,
    input  logic        i_p1_request,
    input  logic [1:0]  i_p1_op,
    input  logic [31:0] i_p1_op1,
    input  logic [31:0] i_p1_op2,
    output logic        o_p0_ready,
    output logic [31:0] o_p0_result,
    output logic        o_p1_ready,
    output logic [31:0] o_p1_result
);

    import cpu_mul_sequencer_pkg::*;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        pref_q, pref_d;
    mul_op_e     op_q, op_d;
    logic [31:0] op1_q, op1_d, op2_q, op2_d;
    logic [31:0] prod_hi_q, prod_hi_d;
    logic [31:0] res0_q, res0_d, res1_q, res1_d;

    logic        w_pick, w_any, w_grant_req, w_hit, w_load;
    logic [31:0] w_load_val, w_in_op1, w_in_op2;
    logic [63:0] w_hit_prod, w_mul_product;
    mul_op_e     w_in_op;
    logic        w_latch, w_signed, w_mul_ready;

    assign w_any       = i_p0_request | i_p1_request;
    // The preference pointer only steers contested grants.
    assign w_pick      = (i_p0_request && i_p1_request) ? ((FIXED_PRIORITY != 0) ? 1'b0 : pref_q)
                                                        : i_p1_request;
    assign w_in_op     = w_pick ? mul_op_e'(i_p1_op) : mul_op_e'(i_p0_op);
    assign w_in_op1    = w_pick ? i_p1_op1 : i_p0_op1;
    assign w_in_op2    = w_pick ? i_p1_op2 : i_p0_op2;
    assign w_grant_req = grant_q ? i_p1_request : i_p0_request;

`ifdef CPU_MUL_RESULT_CACHE_EN
    logic        c_valid_q;
    logic        c_sgn_q;
    logic [31:0] c_op1_q, c_op2_q;
    logic [63:0] c_prod_q;

    assign w_hit = c_valid_q && (w_in_op1 == c_op1_q) && (w_in_op2 == c_op2_q) &&
                   ((w_in_op == MUL_OP_MUL) || ((w_in_op == MUL_OP_MULH) == c_sgn_q));
    assign w_hit_prod = c_prod_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            c_valid_q <= 1'b0;
            c_sgn_q   <= 1'b0;
            c_op1_q   <= 32'd0;
            c_op2_q   <= 32'd0;
            c_prod_q  <= 64'd0;
        end else if ((state_q == ST_WAIT) && w_mul_ready) begin
            c_valid_q <= 1'b1;
            c_sgn_q   <= (op_q == MUL_OP_MULH);
            c_op1_q   <= op1_q;
            c_op2_q   <= op2_q;
            c_prod_q  <= w_mul_product;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_prod = 64'd0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        pref_d     = pref_q;
        op_d       = op_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        prod_hi_d  = prod_hi_q;
        res0_d     = res0_q;
        res1_d     = res1_q;
        w_load     = 1'b0;
        w_load_val = 32'd0;
        case (state_q)
            ST_IDLE: if (w_any) begin
                grant_d = w_pick;
                if (i_p0_request && i_p1_request) pref_d = ~w_pick;
                op_d  = w_in_op;
                op1_d = w_in_op1;
                op2_d = w_in_op2;
                if (!w_hit) begin
                    state_d = ST_ISSUE;
                end else if (w_in_op == MUL_OP_MULHSU) begin
                    prod_hi_d = w_hit_prod[63:32];
                    state_d   = ST_FIXUP;
                end else begin
                    w_load     = 1'b1;
                    w_load_val = select_half(w_in_op, w_hit_prod);
                    state_d    = ST_DONE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: if (w_mul_ready) begin
                prod_hi_d = w_mul_product[63:32];
                if (op_q == MUL_OP_MULHSU) begin
                    state_d = ST_FIXUP;
                end else begin
                    w_load     = 1'b1;
                    w_load_val = select_half(op_q, w_mul_product);
                    state_d    = ST_DONE;
                end
            end
            ST_FIXUP: begin
                w_load     = 1'b1;
                w_load_val = mulhsu_fixup(prod_hi_q, op1_q, op2_q);
                state_d    = ST_DONE;
            end
            ST_DONE: if (!w_grant_req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (w_load) begin
            if (grant_d) res1_d = w_load_val;
            else         res0_d = w_load_val;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            pref_q    <= 1'b0;
            op_q      <= MUL_OP_MUL;
            op1_q     <= 32'd0;
            op2_q     <= 32'd0;
            prod_hi_q <= 32'd0;
            res0_q    <= 32'd0;
            res1_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            pref_q    <= pref_d;
            op_q      <= op_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            prod_hi_q <= prod_hi_d;
            res0_q    <= res0_d;
            res1_q    <= res1_d;
        end
    end

    assign w_latch  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign w_signed = w_latch && (op_q == MUL_OP_MULH);

    CPU_Multiply u_mul (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_latch   (w_latch),
        .i_signed  (w_signed),
        .i_op1     (op1_q),
        .i_op2     (op2_q),
        .o_ready   (w_mul_ready),
        .o_product (w_mul_product)
    );

    assign o_p0_ready  = (state_q == ST_DONE) && !grant_q;
    assign o_p1_ready  = (state_q == ST_DONE) && grant_q;
    assign o_p0_result = res0_q;
    assign o_p1_result = res1_q;

endmodule

`default_nettype wire
